// File: rtl/usart_clk_gen.sv
// usart_clk_gen: baud prescaler, async TX/RX strobes, sync master XCK generation and sync slave XCK edge detection.
module usart_clk_gen #(
  parameter int UBRR_W      = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic              cp2,
  input  logic              ireset,
  input  logic [UBRR_W-1:0] ubrr,
  input  logic              ubrr_wr,
  input  logic              u2x,
  input  logic              umsel,
  input  logic              ucpol,
  input  logic              ddr_xck,
  input  logic              xck_i,
  input  logic              txen,
  input  logic              rxen,
  output logic              xck_o,
  output logic              tx_tick,
  output logic              rx_tick,
  output logic              pre_tick
);
  logic [UBRR_W-1:0]      cnt_q, cnt_d;
  logic                   pre_q, pre_d;
  logic [3:0]             div_q, div_d;
  logic                   xck_q, xck_d;
  logic                   en_q, xp_q, sed_q, srise_q, sfall_q, live_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [1:0]             mode_q;
  logic                   mode_chg, master, wrap, rise, fall;
  always_comb begin
    master   = umsel & ddr_xck;
    mode_chg = live_q && (mode_q != {umsel, ddr_xck});
    pre_d    = !ubrr_wr && (cnt_q == '0);
    cnt_d    = (ubrr_wr || cnt_q == '0) ? ubrr : cnt_q - UBRR_W'(1);
    wrap     = pre_q && (u2x ? div_q[2:0] == 3'd7 : div_q == 4'd15);
    div_d    = (!txen || umsel || mode_chg) ? 4'd0 : div_q + 4'(pre_q & en_q);
    xck_d    = (master && !mode_chg) ? xck_q ^ pre_d : 1'b0;
    rise     = master ? (xck_q & ~xp_q) : srise_q;
    fall     = master ? (~xck_q & xp_q) : sfall_q;
    tx_tick  = !mode_chg && txen && (umsel ? (ucpol ? fall : rise) : wrap);
    rx_tick  = !mode_chg && rxen && (umsel ? (ucpol ? rise : fall) : pre_q);
    pre_tick = pre_q;
    xck_o    = xck_q;
  end
  // en_q delays txen so the first TX bit lands a full 16 (or 8) prescaler ticks after enable
  always_ff @(posedge cp2 or posedge ireset) begin
    if (ireset) begin
      cnt_q   <= '0;
      pre_q   <= 1'b0;
      div_q   <= '0;
      xck_q   <= 1'b0;
      en_q    <= 1'b0;
      xp_q    <= 1'b0;
      sync_q  <= '0;
      sed_q   <= 1'b0;
      srise_q <= 1'b0;
      sfall_q <= 1'b0;
      mode_q  <= '0;
      live_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
      div_q   <= div_d;
      xck_q   <= xck_d;
      en_q    <= txen;
      xp_q    <= xck_q;
      sync_q  <= {sync_q[SYNC_STAGES-2:0], xck_i};
      sed_q   <= sync_q[SYNC_STAGES-1];
      srise_q <= sync_q[SYNC_STAGES-1] & ~sed_q;
      sfall_q <= ~sync_q[SYNC_STAGES-1] & sed_q;
      mode_q  <= {umsel, ddr_xck};
      live_q  <= 1'b1;
    end
  end
endmodule
